alu_exec_ctrl: RTL and testbench
================================

ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter BW, default 16, datapath width; matches ALU BW.
REQ-002 Parameter NREG, default 8, register count; address width AW = $clog2(NREG).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  block accepts instruction this cycle.
REQ-007 instr_opcode  input  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INC, 6 MOVA, 7 MOVB, 8-15 illegal.
REQ-008 instr_dst, instr_srca, instr_srcb  input  AW each  destination and source register indices.
REQ-009 instr_use_imm  input  1  operand B taken from instr_imm instead of register srcb.
REQ-010 instr_imm  input  BW  signed immediate operand.
REQ-011 alu_in_a, alu_in_b  output  BW  signed operands to the ALU.
REQ-012 alu_opcode  output  4  opcode to the ALU.
REQ-013 alu_out  input  BW  signed ALU result (combinational from alu_in_*).
REQ-014 alu_flags  input  3  ALU flags {overflow, negative, zero}.
REQ-015 flags_q  output  3  architectural flags register {overflow, negative, zero}.
REQ-016 done  output  1  one-cycle pulse per retired instruction.
REQ-017 illegal  output  1  last retired instruction had illegal opcode.
REQ-018 dbg_raddr  input  AW / dbg_rdata  output  BW  asynchronous register-file read port.

Function
REQ-019 FSM states IDLE, EXEC, WB; IDLE -> EXEC on instr_valid & instr_ready; EXEC -> WB unconditionally; WB -> IDLE unconditionally.
REQ-020 instr_ready SHALL be 1 only in IDLE; instr_valid while not ready is ignored and not stored.
REQ-021 On acceptance, opcode, dst, srca, srcb, use_imm, imm SHALL be captured into an instruction register.
REQ-022 In EXEC, alu_in_a = rf[srca_q], alu_in_b = use_imm_q ? imm_q : rf[srcb_q], alu_opcode = opcode_q.
REQ-023 In IDLE and WB, alu_in_a, alu_in_b, alu_opcode SHALL be driven to 0.
REQ-024 At the edge ending EXEC, alu_out SHALL be captured into res_q and alu_flags into flags_q.
REQ-025 At the edge ending WB, rf[dst_q] <= res_q; done = 1 during the WB cycle only.
REQ-026 Latency: accept at edge N, flags_q valid after edge N+1, register write visible on dbg_rdata after edge N+2; throughput one instruction per 3 cycles.
REQ-027 Illegal opcode (8-15): no register write, flags_q unchanged, done still pulses, illegal = 1 during WB; illegal cleared on next acceptance.
REQ-028 srca or srcb equal to dst SHALL read the pre-write value (no overlap between instructions).
REQ-029 dbg_raddr equal to dst_q during WB SHALL return the old value; new value from the following cycle.
REQ-030 Register arithmetic is modular BW-bit; no saturation; overflow reported only via flags_q[2].

Reset
REQ-031 rst_n = 0 at a rising edge: FSM to IDLE, all rf entries, res_q, instruction register, flags_q, done, illegal to 0.
REQ-032 Reset during EXEC or WB SHALL abort the instruction: no register write, no done pulse.
REQ-033 instr_ready SHALL be 0 in any cycle with rst_n = 0.

Configuration
REQ-034 Macro ALU_EXEC_R0_ZERO_EN defined: register 0 reads as 0 on all ports and writes to it are discarded (flags_q still updated).
REQ-035 ALU_EXEC_R0_ZERO_EN undefined: register 0 is an ordinary storage register.

Verification
REQ-036 Reset, then MOVB imm 0x7FFF to r1, MOVB imm 0x0001 to r2, ADD r3=r1+r2 -> rf[3]=0x8000, flags_q=3'b110, done pulsed 3 times, each 2 cycles after acceptance.
REQ-037 SUB r4=r3-r3 -> rf[4]=0, flags_q=3'b001; hold instr_valid high through EXEC/WB -> only one acceptance per 3 cycles.
REQ-038 Opcode 4'b1010 to r5 after r5 preloaded 0x1234 -> rf[5] stays 0x1234, flags_q unchanged, illegal=1 and done=1 in WB.
REQ-039 Assert rst_n=0 in EXEC of INC r6 -> rf[6]=0, no done, FSM IDLE with instr_ready=1 the cycle after rst_n returns high.
REQ-040 MOVB imm 0x00AA to r0 -> with ALU_EXEC_R0_ZERO_EN dbg_rdata(r0)=0; without it dbg_rdata(r0)=0x00AA.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: IDLE/EXEC/WB sequencer that feeds an external combinational ALU from a small register file.
// Define ALU_EXEC_R0_ZERO_EN to hard-wire register 0 to zero (reads return 0, writes are dropped).
module alu_exec_ctrl #(
    parameter int  BW   = 16,
    parameter int  NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_opcode,
    input  logic [AW-1:0]        instr_dst,
    input  logic [AW-1:0]        instr_srca,
    input  logic [AW-1:0]        instr_srcb,
    input  logic                 instr_use_imm,
    input  logic signed [BW-1:0] instr_imm,
    output logic signed [BW-1:0] alu_in_a,
    output logic signed [BW-1:0] alu_in_b,
    output logic [3:0]           alu_opcode,
    input  logic signed [BW-1:0] alu_out,
    input  logic [2:0]           alu_flags,
    output logic [2:0]           flags_q,
    output logic                 done,
    output logic                 illegal,
    input  logic [AW-1:0]        dbg_raddr,
    output logic [BW-1:0]        dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic [3:0]    opcode_q, opcode_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] srca_q, srca_d;
    logic [AW-1:0] srcb_q, srcb_d;
    logic          use_imm_q, use_imm_d;
    logic [BW-1:0] imm_q, imm_d;
    logic [BW-1:0] res_q, res_d;
    logic [2:0]    flags_d;
    logic          illegal_q, illegal_d;

    logic [BW-1:0] rf_q [NREG];

    logic          accept;
    logic          opIllegal;
    logic          rfWe;
    logic [BW-1:0] rdA;
    logic [BW-1:0] rdB;

    assign opIllegal = opcode_q[3];
    assign accept    = instr_valid && instr_ready;
    assign illegal   = illegal_q;

`ifdef ALU_EXEC_R0_ZERO_EN
    assign rdA       = (srca_q == '0)    ? '0 : rf_q[srca_q];
    assign rdB       = (srcb_q == '0)    ? '0 : rf_q[srcb_q];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : rf_q[dbg_raddr];
    assign rfWe      = (state_q == WB) && !opIllegal && (dst_q != '0);
`else
    assign rdA       = rf_q[srca_q];
    assign rdB       = rf_q[srcb_q];
    assign dbg_rdata = rf_q[dbg_raddr];
    assign rfWe      = (state_q == WB) && !opIllegal;
`endif

    // Ready is also gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = rst_n;
                if (instr_valid && rst_n) begin
                    state_d = EXEC;
                end
            end
            EXEC: state_d = WB;
            WB: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_in_a   = '0;
        alu_in_b   = '0;
        alu_opcode = '0;
        if (state_q == EXEC) begin
            alu_in_a   = rdA;
            alu_in_b   = use_imm_q ? imm_q : rdB;
            alu_opcode = opcode_q;
        end
    end

    // The ALU result and flags are only meaningful while EXEC presents operands.
    always_comb begin
        opcode_d  = opcode_q;
        dst_d     = dst_q;
        srca_d    = srca_q;
        srcb_d    = srcb_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        res_d     = res_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        if (accept) begin
            opcode_d  = instr_opcode;
            dst_d     = instr_dst;
            srca_d    = instr_srca;
            srcb_d    = instr_srcb;
            use_imm_d = instr_use_imm;
            imm_d     = instr_imm;
            illegal_d = 1'b0;
        end
        if (state_q == EXEC) begin
            res_d     = alu_out;
            illegal_d = opIllegal;
            if (!opIllegal) begin
                flags_d = alu_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            dst_q     <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            rf_q      <= '{default: '0};
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            dst_q     <= dst_d;
            srca_q    <= srca_d;
            srcb_q    <= srcb_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            if (rfWe) begin
                rf_q[dst_q] <= res_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized and directed stimulus for alu_exec_ctrl, checked against an
// instruction-level register-file model; a behavioural ALU stub closes the alu_in/alu_out loop.
module tb_alu_exec_ctrl;

    localparam int BW   = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    localparam longint MAXV = (longint'(1) << (BW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (BW - 1));

`ifdef ALU_EXEC_R0_ZERO_EN
    localparam bit R0Zero = 1'b1;
`else
    localparam bit R0Zero = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    instr_opcode;
    logic [AW-1:0] instr_dst;
    logic [AW-1:0] instr_srca;
    logic [AW-1:0] instr_srcb;
    logic          instr_use_imm;
    logic [BW-1:0] instr_imm;
    logic [BW-1:0] alu_in_a;
    logic [BW-1:0] alu_in_b;
    logic [3:0]    alu_opcode;
    logic [BW-1:0] alu_out;
    logic [2:0]    alu_flags;
    logic [2:0]    flags_q;
    logic          done;
    logic          illegal;
    logic [AW-1:0] dbg_raddr;
    logic [BW-1:0] dbg_rdata;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [BW-1:0] modelRf [NREG];
    logic [2:0]    modelFlags;
    logic          modelIllegal;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.BW(BW), .NREG(NREG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_dst    (instr_dst),
        .instr_srca   (instr_srca),
        .instr_srcb   (instr_srcb),
        .instr_use_imm(instr_use_imm),
        .instr_imm    (instr_imm),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_flags    (alu_flags),
        .flags_q      (flags_q),
        .done         (done),
        .illegal      (illegal),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
    );

    // ALU stub: bit-level overflow rules; illegal opcodes return junk so misuse is visible.
    logic ovfBit;
    always_comb begin
        alu_out = '0;
        ovfBit  = 1'b0;
        case (alu_opcode)
            4'd0: begin
                alu_out = alu_in_a + alu_in_b;
                ovfBit  = (alu_in_a[BW-1] == alu_in_b[BW-1]) && (alu_out[BW-1] != alu_in_a[BW-1]);
            end
            4'd1: begin
                alu_out = alu_in_a - alu_in_b;
                ovfBit  = (alu_in_a[BW-1] != alu_in_b[BW-1]) && (alu_out[BW-1] != alu_in_a[BW-1]);
            end
            4'd2: alu_out = alu_in_a & alu_in_b;
            4'd3: alu_out = alu_in_a | alu_in_b;
            4'd4: alu_out = alu_in_a ^ alu_in_b;
            4'd5: begin
                alu_out = alu_in_a + BW'(1);
                ovfBit  = !alu_in_a[BW-1] && alu_out[BW-1];
            end
            4'd6: alu_out = alu_in_a;
            4'd7: alu_out = alu_in_b;
            default: alu_out = BW'(16'hDEAD);
        endcase
        alu_flags = alu_opcode[3] ? 3'b111 : {ovfBit, alu_out[BW-1], alu_out == '0};
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic longint toSigned(input logic [BW-1:0] v);
        return v[BW-1] ? (longint'(v) - (longint'(1) << BW)) : longint'(v);
    endfunction

    // Instruction-level model: exact integer arithmetic, wrapped to BW bits afterwards.
    task automatic modelCompute(input logic [3:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                                output logic [BW-1:0] res, output logic [2:0] flags, output logic isIll);
        longint full;
        logic   ovf;
        full  = 0;
        isIll = 1'b0;
        case (op)
            4'd0: full = toSigned(a) + toSigned(b);
            4'd1: full = toSigned(a) - toSigned(b);
            4'd2: full = longint'(a & b);
            4'd3: full = longint'(a | b);
            4'd4: full = longint'(a ^ b);
            4'd5: full = toSigned(a) + 1;
            4'd6: full = toSigned(a);
            4'd7: full = toSigned(b);
            default: isIll = 1'b1;
        endcase
        ovf   = (op == 4'd0 || op == 4'd1 || op == 4'd5) && (full > MAXV || full < MINV);
        res   = full[BW-1:0];
        flags = {ovf, res[BW-1], res == '0};
    endtask

    task automatic resetModel();
        modelRf      = '{default: '0};
        modelFlags   = '0;
        modelIllegal = 1'b0;
    endtask

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) checkOutput("readyTimeout", 32'(instr_ready), 1);
    endtask

    task automatic checkReg(input string tag, input logic [AW-1:0] addr, input logic [BW-1:0] expected);
        dbg_raddr = addr;
        @(negedge clk);
        checkOutput(tag, 32'(dbg_rdata), 32'(expected));
    endtask

    // One full instruction: accept, check EXEC operands, WB flags/old value, then IDLE new value.
    task automatic applyStimulus(input logic [3:0] op, input logic [AW-1:0] dst, input logic [AW-1:0] srca,
                                 input logic [AW-1:0] srcb, input logic useImm, input logic [BW-1:0] imm);
        logic [BW-1:0] expA, expB, expRes, oldDst;
        logic [2:0]    expFlags;
        logic          isIll;
        waitReady();
        expA   = modelRf[srca];
        expB   = useImm ? imm : modelRf[srcb];
        oldDst = modelRf[dst];
        modelCompute(op, expA, expB, expRes, expFlags, isIll);
        instr_opcode  = op;
        instr_dst     = dst;
        instr_srca    = srca;
        instr_srcb    = srcb;
        instr_use_imm = useImm;
        instr_imm     = imm;
        instr_valid   = 1'b1;
        @(posedge clk);
        #1;
        instr_valid   = 1'b0;
        instr_opcode  = 4'($urandom_range(0, 15));
        instr_dst     = AW'($urandom);
        instr_srca    = AW'($urandom);
        instr_srcb    = AW'($urandom);
        instr_use_imm = 1'($urandom);
        instr_imm     = BW'($urandom);
        @(negedge clk);
        checkOutput("execOpcode", 32'(alu_opcode), 32'(op));
        checkOutput("execInA", 32'(alu_in_a), 32'(expA));
        checkOutput("execInB", 32'(alu_in_b), 32'(expB));
        checkOutput("execDone", 32'(done), 0);
        checkOutput("execIllegal", 32'(illegal), 0);
        checkOutput("execReady", 32'(instr_ready), 0);
        dbg_raddr = dst;
        @(negedge clk);
        if (!isIll) modelFlags = expFlags;
        checkOutput("wbDone", 32'(done), 1);
        checkOutput("wbIllegal", 32'(illegal), 32'(isIll));
        checkOutput("wbFlags", 32'(flags_q), 32'(modelFlags));
        checkOutput("wbOldValue", 32'(dbg_rdata), 32'(oldDst));
        checkOutput("wbAluIdle", 32'(alu_opcode) | 32'(alu_in_a) | 32'(alu_in_b), 0);
        if (!isIll && !(R0Zero && dst == '0)) modelRf[dst] = expRes;
        modelIllegal = isIll;
        @(negedge clk);
        checkOutput("idleDone", 32'(done), 0);
        checkOutput("idleReady", 32'(instr_ready), 1);
        checkOutput("idleIllegal", 32'(illegal), 32'(modelIllegal));
        checkOutput("newValue", 32'(dbg_rdata), 32'(modelRf[dst]));
    endtask

    // Valid held high through EXEC/WB with changing fields: only the first offer may be taken.
    task automatic holdValidTest();
        logic [BW-1:0] expRes;
        logic [2:0]    expFlags;
        logic          isIll;
        int            extraAccepts = 0;
        waitReady();
        modelCompute(4'd1, modelRf[3], modelRf[3], expRes, expFlags, isIll);
        instr_opcode  = 4'd1;
        instr_dst     = AW'(4);
        instr_srca    = AW'(3);
        instr_srcb    = AW'(3);
        instr_use_imm = 1'b0;
        instr_valid   = 1'b1;
        @(posedge clk);
        #1;
        instr_opcode  = 4'd7;
        instr_dst     = AW'(7);
        instr_use_imm = 1'b1;
        instr_imm     = BW'(16'h5555);
        @(negedge clk);
        if (instr_ready) extraAccepts++;
        @(negedge clk);
        if (instr_ready) extraAccepts++;
        checkOutput("holdWbDone", 32'(done), 1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        modelRf[4]  = expRes;
        modelFlags  = expFlags;
        @(negedge clk);
        checkOutput("holdExtraAccepts", 32'(extraAccepts), 0);
        checkOutput("holdFlags", 32'(flags_q), 32'(3'b001));
        checkReg("holdR4", AW'(4), '0);
        checkReg("holdR7", AW'(7), modelRf[7]);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        instr_valid   = 1'b0;
        instr_opcode  = '0;
        instr_dst     = '0;
        instr_srca    = '0;
        instr_srcb    = '0;
        instr_use_imm = 1'b0;
        instr_imm     = '0;
        dbg_raddr     = '0;
        resetModel();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReady", 32'(instr_ready), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstFlags", 32'(flags_q), 0);
        checkOutput("rstIllegal", 32'(illegal), 0);
        checkOutput("rstAluOpcode", 32'(alu_opcode), 0);
        for (int i = 0; i < NREG; i++) checkReg("rstRf", AW'(i), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(4'd7, AW'(1), AW'(0), AW'(0), 1'b1, BW'(16'h7FFF));
        applyStimulus(4'd7, AW'(2), AW'(0), AW'(0), 1'b1, BW'(16'h0001));
        applyStimulus(4'd0, AW'(3), AW'(1), AW'(2), 1'b0, '0);
        checkReg("addR3", AW'(3), BW'(16'h8000));
        checkOutput("addFlags", 32'(flags_q), 32'(3'b110));

        holdValidTest();

        applyStimulus(4'd7, AW'(5), AW'(0), AW'(0), 1'b1, BW'(16'h1234));
        applyStimulus(4'b1010, AW'(5), AW'(1), AW'(2), 1'b0, '0);
        checkReg("illegalR5", AW'(5), BW'(16'h1234));
        checkOutput("illegalSticky", 32'(illegal), 1);

        applyStimulus(4'd7, AW'(0), AW'(0), AW'(0), 1'b1, BW'(16'h00AA));
        checkReg("r0Write", AW'(0), R0Zero ? '0 : BW'(16'h00AA));

        applyStimulus(4'd5, AW'(1), AW'(1), AW'(0), 1'b0, '0);
        checkReg("incWrap", AW'(1), BW'(16'h8000));

        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            applyStimulus(op, AW'($urandom), AW'($urandom), AW'($urandom), 1'($urandom), BW'($urandom));
        end

        // Reset asserted during EXEC of INC r6 must abort it.
        waitReady();
        instr_opcode  = 4'd5;
        instr_dst     = AW'(6);
        instr_srca    = AW'(6);
        instr_use_imm = 1'b0;
        instr_valid   = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        checkOutput("rstExecReady", 32'(instr_ready), 0);
        @(negedge clk);
        checkOutput("rstAbortDone", 32'(done), 0);
        checkOutput("rstHeldReady", 32'(instr_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        resetModel();
        @(negedge clk);
        checkOutput("postRstReady", 32'(instr_ready), 1);
        checkOutput("postRstDone", 32'(done), 0);
        checkOutput("postRstFlags", 32'(flags_q), 0);
        checkReg("postRstR6", AW'(6), '0);

        applyStimulus(4'd7, AW'(6), AW'(0), AW'(0), 1'b1, BW'(16'h0F0F));
        applyStimulus(4'd4, AW'(2), AW'(6), AW'(6), 1'b1, BW'(16'hFFFF));
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'($urandom_range(0, 7)), AW'($urandom), AW'($urandom), AW'($urandom),
                          1'($urandom), BW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
